// File: rtl/uart_tx_line_arbiter_pkg.sv
// Shared types and constants for the UART TX line arbiter and its 8N1 serializer.
package uart_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  localparam int FrameBits = 10;
  localparam logic [7:0] NewlineChar = 8'h0A;

  function automatic int cycles_per_symbol(input int unsigned freq, input int unsigned baud);
    return (baud == 0) ? 0 : int'(freq / baud);
  endfunction

endpackage

// File: rtl/uart_tx_line_arbiter_ser.sv
// 8N1 serializer: accepts one byte on valid/ready and shifts {stop, data, start} out LSB first.
module uart_tx_ser
  import uart_arb_pkg::*;
#(
  parameter int CyclesPerSymbol = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       active_o
);

  localparam int CycW = (CyclesPerSymbol > 1) ? $clog2(CyclesPerSymbol) : 1;
  localparam int BitW = $clog2(FrameBits);
  localparam logic [CycW-1:0] CycLast = CycW'(CyclesPerSymbol - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);

  if (CyclesPerSymbol < 2) begin : g_bad_rate
    $error("uart_tx_ser: CyclesPerSymbol must be at least 2");
  end

  logic                 active_q, active_d;
  logic [FrameBits-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CycW-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic                 sym_end;
  logic                 accept;

  assign sym_end  = (cyc_cnt_q == CycLast);
  // Ready during the final stop-bit cycle lets the next frame start with no idle gap.
  assign ready_o  = !active_q || (sym_end && (bit_cnt_q == BitLast));
  assign accept   = valid_i && ready_o;
  assign tx_o     = shreg_q[0];
  assign active_o = active_q;

  always_comb begin
    active_d  = active_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    if (accept) begin
      active_d  = 1'b1;
      shreg_d   = {1'b1, data_i, 1'b0};
      bit_cnt_d = '0;
      cyc_cnt_d = '0;
    end else if (active_q) begin
      if (sym_end) begin
        cyc_cnt_d = '0;
        if (bit_cnt_q == BitLast) begin
          active_d = 1'b0;
          shreg_d  = '1;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          shreg_d   = {1'b1, shreg_q[FrameBits-1:1]};
        end
      end else begin
        cyc_cnt_d = cyc_cnt_q + CycW'(1);
      end
    end
  end

  // Shift register idles at all-ones so the line is high whenever no frame is loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else begin
      active_q  <= active_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// Round-robin arbiter that locks the shared UART TX line to one requester until it
// sends a newline or stays quiet for LockTimeout cycles, so printed lines never interleave.
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NumReq      = 4,
  parameter int unsigned FREQ        = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned LockTimeout = 1024,
  localparam int         OwnerW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq-1:0][7:0] req_data_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic [OwnerW-1:0]      owner_o
);

  localparam int CyclesPerSymbol = cycles_per_symbol(FREQ, BAUD);
  localparam int TimerW = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;

  if (NumReq < 1) begin : g_bad_numreq
    $error("uart_tx_line_arbiter: NumReq must be at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic              pick_valid;
  logic [OwnerW-1:0] pick_idx;
  logic              own_valid;
  logic [7:0]        own_data;
  logic [OwnerW-1:0] owner_next;
  logic [TimerW-1:0] timer_inc;
  logic              ser_valid;
  logic [7:0]        ser_data;
  logic              ser_ready;
  logic              ser_active;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int off = 0; off < NumReq; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!pick_valid && req_valid_i[OwnerW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = OwnerW'(cand);
      end
    end
  end

  assign own_valid  = req_valid_i[owner_q];
  assign own_data   = req_data_i[owner_q];
  assign owner_next = (int'(owner_q) == NumReq - 1) ? '0 : owner_q + OwnerW'(1);
  assign timer_inc  = timer_q + TimerW'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    req_ready_o = '0;
    ser_valid   = 1'b0;
    ser_data    = own_data;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          timer_d = '0;
        end
      end
      LOCKED: begin
        req_ready_o[owner_q] = ser_ready;
        ser_valid            = own_valid;
        if (own_valid && ser_ready) begin
          timer_d = '0;
          if (own_data == NewlineChar) begin
            state_d  = IDLE;
            rr_ptr_d = owner_next;
          end
        end else if (!own_valid && ser_ready && (LockTimeout != 0)) begin
          // Only quiet cycles with the serializer free count toward releasing the lock.
          timer_d = timer_inc;
          if (timer_inc == TimerW'(LockTimeout)) begin
            state_d  = IDLE;
            rr_ptr_d = owner_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

  uart_tx_ser #(
    .CyclesPerSymbol(CyclesPerSymbol)
  ) u_ser (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (ser_valid),
    .data_i  (ser_data),
    .ready_o (ser_ready),
    .tx_o    (tx_o),
    .active_o(ser_active)
  );

  assign busy_o  = (state_q == LOCKED) || ser_active;
  assign owner_o = owner_q;

endmodule
